// File: rtl/ieeedrv_sd_arb_if.sv
// Host SD channel between the subdrive arbiter (master) and the host side (slave).
interface ieeedrv_sd_arb_if #(
  parameter int BLK_BITS = 8
);
  logic [31:0]         hps_lba;
  logic [5:0]          hps_blk_cnt;
  logic                hps_rd;
  logic                hps_wr;
  logic                hps_ack;
  logic [BLK_BITS-1:0] hps_buff_addr;
  logic                hps_buff_wr;

  modport master (
    output hps_lba, hps_blk_cnt, hps_rd, hps_wr,
    input  hps_ack, hps_buff_addr, hps_buff_wr
  );

  modport slave (
    input  hps_lba, hps_blk_cnt, hps_rd, hps_wr,
    output hps_ack, hps_buff_addr, hps_buff_wr
  );
endinterface

// File: rtl/ieeedrv_sd_arb.sv
// Serialises per-subdrive SD track requests onto the single host SD channel and maps
// host buffer bytes to track-RAM offsets. Optional REQ timeout: IEEEDRV_SDARB_TIMEOUT_EN.
module ieeedrv_sd_arb #(
  parameter  int SUBDRV   = 2,
  parameter  int BLK_BITS = 8,
  localparam int DW       = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [SUBDRV-1:0][31:0] req_lba,
  input  logic [SUBDRV-1:0][5:0]  req_blk_cnt,
  input  logic [SUBDRV-1:0]       req_rd,
  input  logic [SUBDRV-1:0]       req_wr,
  output logic [SUBDRV-1:0]       req_ack,
  ieeedrv_sd_arb_if.master        hps,
  output logic [6+BLK_BITS-1:0]   buf_addr,
  output logic                    buf_we,
  output logic [DW-1:0]           buf_drv,
  output logic                    active
);
  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t            state_q, state_d;
  logic [31:0]       lba_q, lba_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        blk_q, blk_d, blk_now;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              op_rd_q, op_rd_d;
  logic              active_q, active_d;
  logic              arm_q, arm_d;
  logic [DW-1:0]     drv_q, drv_d, rr_q, rr_d;
  logic [SUBDRV-1:0] ack_q, ack_d;
  logic [DW-1:0]     pick_idx, slot;
  logic              pick_vld;
  logic              wrap, timeout;

  // Round-robin: scan downward so the slot right after rr overwrites last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    slot     = '0;
    for (int i = SUBDRV; i >= 1; i--) begin
      slot = DW'((int'(rr_q) + i) % SUBDRV);
      if (req_rd[slot] | req_wr[slot]) begin
        pick_vld = 1'b1;
        pick_idx = slot;
      end
    end
  end

`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  logic [23:0] to_cnt_q, to_cnt_d;
  assign to_cnt_d = (state_q == REQ) ? to_cnt_q + 24'd1 : '0;
  assign timeout  = (state_q == REQ) && (to_cnt_q == '1);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
`else
  assign timeout = 1'b0;
`endif

  // A wrap is armed by seeing all-ones under ack and fires when the address returns
  // to zero; folding it into blk_now keeps buf_addr right on the first byte of a block.
  assign arm_d   = (state_q == XFER) & hps.hps_ack & (&hps.hps_buff_addr);
  assign wrap    = (state_q == XFER) & hps.hps_ack & arm_q & ~(|hps.hps_buff_addr);
  assign blk_now = (wrap && blk_q != cnt_q) ? blk_q + 6'd1 : blk_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld) state_d = REQ;
      REQ:     if (hps.hps_ack) state_d = XFER;
               else if (timeout) state_d = IDLE;
      XFER:    if (!hps.hps_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    blk_d    = blk_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    op_rd_d  = op_rd_q;
    active_d = active_q;
    drv_d    = drv_q;
    rr_d     = rr_q;
    ack_d    = ack_q;
    case (state_q)
      IDLE: begin
        ack_d = '0;
        if (pick_vld) begin
          lba_d    = req_lba[pick_idx];
          cnt_d    = req_blk_cnt[pick_idx];
          op_rd_d  = req_rd[pick_idx];
          rd_d     = req_rd[pick_idx];
          wr_d     = ~req_rd[pick_idx];
          drv_d    = pick_idx;
          blk_d    = '0;
          active_d = 1'b1;
        end
      end
      REQ: begin
        if (hps.hps_ack) begin
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          ack_d        = '0;
          ack_d[drv_q] = 1'b1;
        end else if (timeout) begin
          // One-cycle ack lets the loader drop its busy flag on an abandoned request.
          rd_d         = 1'b0;
          wr_d         = 1'b0;
          ack_d        = '0;
          ack_d[drv_q] = 1'b1;
          active_d     = 1'b0;
          rr_d         = drv_q;
        end
      end
      XFER: begin
        blk_d = blk_now;
        if (!hps.hps_ack) begin
          ack_d    = '0;
          active_d = 1'b0;
          rr_d     = drv_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      lba_q    <= '0;
      cnt_q    <= '0;
      blk_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      op_rd_q  <= 1'b0;
      active_q <= 1'b0;
      arm_q    <= 1'b0;
      drv_q    <= '0;
      rr_q     <= '0;
      ack_q    <= '0;
    end else begin
      state_q  <= state_d;
      lba_q    <= lba_d;
      cnt_q    <= cnt_d;
      blk_q    <= blk_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      op_rd_q  <= op_rd_d;
      active_q <= active_d;
      arm_q    <= arm_d;
      drv_q    <= drv_d;
      rr_q     <= rr_d;
      ack_q    <= ack_d;
    end
  end

  assign hps.hps_lba     = lba_q;
  assign hps.hps_blk_cnt = cnt_q;
  assign hps.hps_rd      = rd_q;
  assign hps.hps_wr      = wr_q;
  assign req_ack         = ack_q;
  assign buf_drv         = drv_q;
  assign active          = active_q;
  assign buf_addr        = {blk_now, hps.hps_buff_addr};
  assign buf_we          = hps.hps_buff_wr & hps.hps_ack & op_rd_q & active_q;
endmodule
